// File: rtl/gp_engine_pkg.sv
// Shared types and constants for the GP engine sequencing logic.
package gp_engine_pkg;

  localparam int NUM_TRIG_SRC = 4;
  localparam int CFG_EN_BIT   = 0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_CFG,
    ARB,
    ISSUE,
    WAIT_DONE
  } sched_state_e;

endpackage

// File: rtl/gp_trigger_scheduler_if.sv
// Command channel between the trigger scheduler and the execution engine.
interface gp_trigger_scheduler_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_src;
  logic [DATA_WIDTH-1:0] cmd_cfg;
  logic                  cmd_done;

  modport master (
    output cmd_valid,
    output cmd_src,
    output cmd_cfg,
    input  cmd_ready,
    input  cmd_done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_src,
    input  cmd_cfg,
    output cmd_ready,
    output cmd_done
  );

endinterface

// File: rtl/gp_rr_arbiter.sv
// Combinational 4-way round-robin arbiter; the search starts one past ptr.
module gp_rr_arbiter
  import gp_engine_pkg::*;
(
  input  logic [NUM_TRIG_SRC-1:0] req,
  input  logic [1:0]              ptr,
  output logic [NUM_TRIG_SRC-1:0] grant,
  output logic [1:0]              grant_idx,
  output logic                    grant_valid
);

  logic [1:0] cand;

  // Scan from farthest to nearest so the nearest requester after ptr wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = NUM_TRIG_SRC; i >= 1; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gp_trigger_scheduler.sv
// Captures triggers, fetches their configuration, and issues one supervised command at a time.
module gp_trigger_scheduler
  import gp_engine_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [3:0]            trig,
  output logic                  reg_rd_en,
  input  logic                  reg_rd_valid,
  input  logic [DATA_WIDTH-1:0] rd_trig_s1_config,
  input  logic [DATA_WIDTH-1:0] rd_trig_s2_config,
  input  logic [DATA_WIDTH-1:0] rd_trig_s3_config,
  input  logic [DATA_WIDTH-1:0] rd_trig_s4_config,
  gp_trigger_scheduler_if.master cmd,
  output logic                  busy,
  output logic                  err_timeout,
  output logic [1:0]            err_src
);

  localparam int CNT_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int LAST_CNT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sched_state_e            state, next_state;
  logic [NUM_TRIG_SRC-1:0] pend, pend_clr, en_vec, elig;
  logic [DATA_WIDTH-1:0]   cfg_q [NUM_TRIG_SRC];
  logic [NUM_TRIG_SRC-1:0] grant;
  logic [1:0]              grant_idx, rr_ptr, cmd_src_q, err_src_q;
  logic                    grant_valid, handshake, timeout_hit;
  logic [DATA_WIDTH-1:0]   cmd_cfg_q;
  logic [CNT_W-1:0]        timeout_cnt;

  always_comb begin
    en_vec = '0;
    for (int i = 0; i < NUM_TRIG_SRC; i++) en_vec[i] = cfg_q[i][CFG_EN_BIT];
  end

  assign elig        = pend & en_vec;
  assign pend_clr    = (state == ARB) ? ((pend & ~en_vec) | grant) : '0;
  assign handshake   = (state == ISSUE) && cmd.cmd_ready;
  // A done pulse in the final counted cycle beats the timeout.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == WAIT_DONE) && !cmd.cmd_done &&
                       (timeout_cnt == CNT_W'(LAST_CNT));

  gp_rr_arbiter u_arb (
    .req         (elig),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (|pend) next_state = FETCH;
      FETCH:     next_state = WAIT_CFG;
      WAIT_CFG:  if (reg_rd_valid) next_state = ARB;
      ARB:       next_state = grant_valid ? ISSUE : IDLE;
      ISSUE:     if (cmd.cmd_ready) next_state = WAIT_DONE;
      WAIT_DONE: if (cmd.cmd_done || timeout_hit) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    reg_rd_en     = (state == FETCH);
    cmd.cmd_valid = (state == ISSUE);
    busy          = (state != IDLE);
    err_timeout   = timeout_hit;
    cmd.cmd_src   = cmd_src_q;
    cmd.cmd_cfg   = cmd_cfg_q;
    err_src       = err_src_q;
  end

  // Set-over-clear on pend lets a retrigger during service queue exactly once.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pend        <= '0;
      rr_ptr      <= 2'd3;
      cmd_src_q   <= '0;
      cmd_cfg_q   <= '0;
      err_src_q   <= '0;
      timeout_cnt <= '0;
      for (int i = 0; i < NUM_TRIG_SRC; i++) cfg_q[i] <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | trig;
      if (state == WAIT_CFG && reg_rd_valid) begin
        cfg_q[0] <= rd_trig_s1_config;
        cfg_q[1] <= rd_trig_s2_config;
        cfg_q[2] <= rd_trig_s3_config;
        cfg_q[3] <= rd_trig_s4_config;
      end
      if (state == ARB && grant_valid) begin
        rr_ptr    <= grant_idx;
        cmd_src_q <= grant_idx;
        cmd_cfg_q <= cfg_q[grant_idx];
      end
      if (handshake) timeout_cnt <= '0;
      else if (state == WAIT_DONE && timeout_cnt != CNT_MAX) timeout_cnt <= timeout_cnt + 1'b1;
      if (timeout_hit) err_src_q <= cmd_src_q;
    end
  end

endmodule

// File: tb/tb_gp_trigger_scheduler.sv
// Directed scoreboard bench for gp_trigger_scheduler with a register-file and engine model.
module tb_gp_trigger_scheduler;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] cfg;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic [3:0]  trig = '0;
  logic        reg_rd_en, reg_rd_valid = 1'b0;
  logic [31:0] cfg_s [4];
  logic        busy, err_timeout;
  logic [1:0]  err_src;

  int          pass_cnt = 0, check_cnt = 0;
  int          cycle_cnt = 0, hs_cycle = 0;
  int          stall_left = 0, done_lat = 3, done_cd = 0;
  logic        rd_seen = 1'b0;
  exp_t        exp_q [$];
  logic [31:0] c_val [4];

  gp_trigger_scheduler_if #(.DATA_WIDTH(32)) cmd_bus ();

  gp_trigger_scheduler #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .i_clk             (i_clk),
    .i_rstn            (i_rstn),
    .trig              (trig),
    .reg_rd_en         (reg_rd_en),
    .reg_rd_valid      (reg_rd_valid),
    .rd_trig_s1_config (cfg_s[0]),
    .rd_trig_s2_config (cfg_s[1]),
    .rd_trig_s3_config (cfg_s[2]),
    .rd_trig_s4_config (cfg_s[3]),
    .cmd               (cmd_bus.master),
    .busy              (busy),
    .err_timeout       (err_timeout),
    .err_src           (err_src)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [3:0] t);
    @(negedge i_clk);
    trig = t;
    @(negedge i_clk);
    trig = '0;
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_rstn = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rstn = 1'b1;
  endtask

  task automatic waitDrain(input string name, input int max_cycles);
    int n = 0;
    do begin
      @(negedge i_clk);
      #1;
      n++;
    end while ((exp_q.size() != 0 || busy) && n < max_cycles);
    checkOutput(name, 64'(n < max_cycles), 64'd1);
  endtask

  task automatic waitValid(input string name, input int max_cycles);
    int n = 0;
    do begin
      @(negedge i_clk);
      #1;
      n++;
    end while (!cmd_bus.cmd_valid && n < max_cycles);
    checkOutput(name, 64'(n < max_cycles), 64'd1);
  endtask

  // Register file answers one cycle after each read request.
  initial begin
    forever begin
      @(negedge i_clk);
      reg_rd_valid = rd_seen;
      rd_seen      = reg_rd_en;
    end
  end

  // Engine model: optional ready stall, done pulse done_lat cycles after handshake (0 = never).
  initial begin
    cmd_bus.cmd_ready = 1'b0;
    cmd_bus.cmd_done  = 1'b0;
    forever begin
      @(negedge i_clk);
      cmd_bus.cmd_done  = 1'b0;
      cmd_bus.cmd_ready = 1'b0;
      if (done_cd > 0) begin
        done_cd--;
        if (done_cd == 0) cmd_bus.cmd_done = 1'b1;
      end
      if (cmd_bus.cmd_valid) begin
        if (stall_left > 0) stall_left--;
        else begin
          cmd_bus.cmd_ready = 1'b1;
          done_cd = done_lat;
        end
      end
    end
  end

  // Scoreboard monitor: every accepted command must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      #1;
      if (i_rstn && cmd_bus.cmd_valid && cmd_bus.cmd_ready) begin
        hs_cycle = cycle_cnt;
        if (exp_q.size() == 0) checkOutput("unexpected_cmd_queue_depth", 64'd0, 64'd1);
        else begin
          e = exp_q.pop_front();
          checkOutput("cmd_src", 64'(cmd_bus.cmd_src), 64'(e.src));
          checkOutput("cmd_cfg", 64'(cmd_bus.cmd_cfg), 64'(e.cfg));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic saw_busy;
    c_val[0] = 32'hDEAD_BEE1;
    c_val[1] = 32'h0000_0003;
    c_val[2] = 32'hA5A5_5A5B;
    c_val[3] = 32'h8000_0001;
    for (int i = 0; i < 4; i++) cfg_s[i] = 32'h0000_0001;

    // Reset state
    repeat (3) @(negedge i_clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_cmd_valid", 64'(cmd_bus.cmd_valid), 64'd0);
    checkOutput("rst_reg_rd_en", 64'(reg_rd_en), 64'd0);
    checkOutput("rst_err", 64'({err_timeout, err_src}), 64'd0);
    checkOutput("rst_cmd_src_cfg", 64'({cmd_bus.cmd_src, cmd_bus.cmd_cfg}), 64'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // Single trigger latency
    $display("[TB] single trigger, source 0");
    exp_q.push_back('{src: 2'd0, cfg: 32'h1});
    applyStimulus(4'b0001);
    #1 checkOutput("lat_c1_rd_en", 64'(reg_rd_en), 64'd0);
    @(negedge i_clk); #1 checkOutput("lat_c2_rd_en", 64'(reg_rd_en), 64'd1);
    @(negedge i_clk); #1 checkOutput("lat_c3_rd_en", 64'(reg_rd_en), 64'd0);
    @(negedge i_clk); #1 checkOutput("lat_c4_valid", 64'(cmd_bus.cmd_valid), 64'd0);
    @(negedge i_clk); #1 checkOutput("lat_c5_valid", 64'(cmd_bus.cmd_valid), 64'd1);
    waitDrain("t1_drain", 50);
    checkOutput("t1_busy_after", 64'(busy), 64'd0);

    // Disabled source is dropped
    $display("[TB] disabled source 1");
    cfg_s[1] = 32'h0;
    applyStimulus(4'b0010);
    #1;
    repeat (3) @(negedge i_clk);
    #1 checkOutput("drop_c4_busy", 64'(busy), 64'd1);
    @(negedge i_clk); #1 checkOutput("drop_c5_busy", 64'({busy, cmd_bus.cmd_valid}), 64'd0);
    cfg_s[1] = 32'h1;
    saw_busy = 1'b0;
    repeat (10) begin
      @(negedge i_clk);
      #1 saw_busy |= busy;
    end
    checkOutput("drop_pend_cleared", 64'(saw_busy), 64'd0);

    // Four sources in round-robin order, then wrap from source 3
    $display("[TB] round robin 1111 then 1001");
    doReset();
    for (int i = 0; i < 4; i++) cfg_s[i] = c_val[i];
    for (int i = 0; i < 4; i++) exp_q.push_back('{src: 2'(i), cfg: c_val[i]});
    applyStimulus(4'b1111);
    waitDrain("rr4_drain", 200);
    exp_q.push_back('{src: 2'd0, cfg: c_val[0]});
    exp_q.push_back('{src: 2'd3, cfg: c_val[3]});
    applyStimulus(4'b1001);
    waitDrain("rr_wrap_drain", 100);

    // Ready stall with a retrigger during ISSUE
    $display("[TB] ready stall");
    stall_left = 20;
    exp_q.push_back('{src: 2'd0, cfg: c_val[0]});
    exp_q.push_back('{src: 2'd0, cfg: c_val[0]});
    applyStimulus(4'b0001);
    waitValid("stall_valid_rise", 20);
    for (int i = 0; i < 15; i++) begin
      @(negedge i_clk);
      #1;
      if (i == 5) trig = 4'b0001;
      if (i == 6) trig = 4'b0000;
      checkOutput($sformatf("stall_hold_%0d", i),
                  64'({cmd_bus.cmd_valid, cmd_bus.cmd_ready, cmd_bus.cmd_src, cmd_bus.cmd_cfg}),
                  64'({1'b1, 1'b0, 2'd0, c_val[0]}));
    end
    waitDrain("stall_drain", 100);

    // Timeout: engine never completes
    $display("[TB] timeout");
    done_lat = 0;
    exp_q.push_back('{src: 2'd2, cfg: c_val[2]});
    applyStimulus(4'b0100);
    n = 0;
    do begin
      @(negedge i_clk);
      #1;
      n++;
    end while (!err_timeout && n < 60);
    checkOutput("tmo_seen", 64'(err_timeout), 64'd1);
    checkOutput("tmo_delay", 64'(cycle_cnt - hs_cycle), 64'd16);
    @(negedge i_clk);
    #1;
    checkOutput("tmo_err_src", 64'(err_src), 64'd2);
    checkOutput("tmo_pulse_end", 64'({err_timeout, busy}), 64'd0);
    done_lat = 3;

    // Reset during ISSUE
    $display("[TB] reset mid issue");
    stall_left = 50;
    applyStimulus(4'b0010);
    waitValid("rst_issue_valid", 20);
    trig = 4'b1000;
    @(negedge i_clk);
    #1 trig = 4'b0000;
    i_rstn = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 64'(cmd_bus.cmd_valid), 64'd0);
    checkOutput("rst_mid_err_src", 64'(err_src), 64'd0);
    stall_left = 0;
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    saw_busy = 1'b0;
    repeat (10) begin
      @(negedge i_clk);
      #1 saw_busy |= busy;
    end
    checkOutput("rst_pend_lost", 64'(saw_busy), 64'd0);
    exp_q.push_back('{src: 2'd0, cfg: c_val[0]});
    exp_q.push_back('{src: 2'd1, cfg: c_val[1]});
    applyStimulus(4'b0011);
    waitDrain("rst_after_drain", 100);

    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/gp_trigger_scheduler.md
# gp_trigger_scheduler

Sequencing controller for the GP engine. It captures trigger events from four sources and fetches their configuration words from the trigger-configuration register file through its FSM read port. It then arbitrates round-robin among pending, enabled sources and issues one command at a time to the downstream execution engine, supervising each command to completion or timeout.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each configuration word and of the command payload.
- TIMEOUT_CYCLES, 1024, number of WAIT_DONE cycles before timeout. 0 disables the timeout.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- trig  in  4  trigger requests. Bit i is source i+1. Sampled every cycle.
- reg_rd_en  out  1  register-file configuration read request, one-cycle pulse.
- reg_rd_valid  in  1  register-file read data valid.
- rd_trig_s1_config .. rd_trig_s4_config  in  DATA_WIDTH each  configuration words from the register file.
- cmd_valid  out  1  command valid to the engine.
- cmd_ready  in  1  engine accepts the command.
- cmd_src  out  2  granted source index, 0..3.
- cmd_cfg  out  DATA_WIDTH  configuration word of the granted source.
- cmd_done  in  1  engine completion pulse.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  one-cycle pulse on timeout.
- err_src  out  2  source of the last timeout. Holds its value until the next timeout.

## Operation
- Pending register pend[3:0]:
  - A bit is set on any cycle where trig[i]=1.
  - A bit is cleared when its source is granted, or when it is dropped because the source is disabled.
  - If set and clear hit the same bit in the same cycle, set wins. A retrigger during service is therefore queued once; triggers do not accumulate.
- Enable rule: a source is enabled when cfg[0]=1. The full word, bit 0 included, is forwarded unchanged on cmd_cfg.
- FSM states: IDLE, FETCH, WAIT_CFG, ARB, ISSUE, WAIT_DONE.
  - IDLE: if pend != 0, go to FETCH.
  - FETCH: assert reg_rd_en for exactly one cycle, then go to WAIT_CFG.
  - WAIT_CFG: on reg_rd_valid, latch all four configuration words into local copies, then go to ARB. Wait indefinitely otherwise.
  - ARB: take the set of pending sources whose latched cfg[0]=1. Clear pend for every pending source with cfg[0]=0 (dropped).
    - If the eligible set is empty, go to IDLE.
    - Otherwise grant the first eligible source, searching from rr_ptr+1 with modulo-4 wrap. Set rr_ptr to the grant, clear its pend bit, and go to ISSUE.
  - ISSUE: drive cmd_valid=1 with cmd_src and cmd_cfg held stable. When cmd_valid and cmd_ready are both high, go to WAIT_DONE and zero the timeout counter.
  - WAIT_DONE: on cmd_done, go to IDLE. Otherwise increment the counter. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), pulse err_timeout, load err_src with the granted source, and go to IDLE.
- cmd_done outside WAIT_DONE is ignored.
- Configuration is re-fetched for every grant, so register writes take effect at the next arbitration.

## Timing
- Reset values:
  - State IDLE, pend=0.
  - rr_ptr=3, so source 0 wins the first arbitration.
  - All outputs 0: reg_rd_en, cmd_valid, cmd_src, cmd_cfg, busy, err_timeout, err_src.
- Reset asserted mid-operation aborts immediately. cmd_valid drops asynchronously and pending triggers are lost.
- Trigger-to-command latency, with the register file answering one cycle after reg_rd_en:
  - trig high in cycle 0.
  - pend set at edge 1.
  - FETCH in cycle 2.
  - reg_rd_valid in cycle 3.
  - ARB in cycle 4.
  - cmd_valid high from cycle 5.
- Back-to-back commands: WAIT_DONE goes to IDLE, then IDLE goes to FETCH in the following cycle. The minimum gap between handshakes is therefore 6 cycles plus the engine's done latency.
- cmd_valid, once raised, never drops before handshake, except on reset.
- The timeout counter width is $clog2(TIMEOUT_CYCLES+1). When TIMEOUT_CYCLES=0 the counter saturates and never fires.
- cmd_done and the timeout in the same cycle: done wins and no error is reported.

## Structure
- Shared package gp_engine_pkg holds:
  - The sched_state_e enum.
  - NUM_TRIG_SRC=4.
  - CFG_EN_BIT=0.
- Sub-module gp_rr_arbiter: combinational 4-way round-robin. Inputs are request and pointer; outputs are the one-hot grant, the encoded index, and a valid flag. The scheduler owns the rr_ptr register.

## Test plan
- All cfg=32'h0000_0001, trig=4'b0001 pulse → reg_rd_en one cycle later, then cmd_valid with cmd_src=0 and cmd_cfg=32'h1. After cmd_ready and cmd_done, busy falls.
- cfg[1]=32'h0 (source 1 disabled), trig=4'b0010 → no cmd_valid, pend[1] cleared, return to IDLE after ARB.
- trig=4'b1111 held one cycle, all enabled, done three cycles after each handshake → four commands in order src 0,1,2,3. Then trig=4'b1001 → order 0, then 3 (round-robin wraps from rr_ptr=3).
- cmd_ready held low 20 cycles → cmd_valid stays high and cmd_src/cmd_cfg are stable. trig[0] pulse during ISSUE → a second command for src 0 follows.
- TIMEOUT_CYCLES=16, cmd_done never asserted → err_timeout pulses 16 cycles after the handshake with err_src equal to the granted source, then the FSM returns to IDLE.
- i_rstn pulled low mid-ISSUE → cmd_valid=0 immediately. After reset release, pend=0 and the first grant goes to src 0.
